// File: rtl/switch_led_arbiter_if.sv
// Switch-to-LED bundle shared between the board pins and the arbiter.
// master: board/driver side (drives switches, observes LEDs).
// slave:  arbiter side (observes switches, drives LEDs).
interface switch_led_arbiter_if;
  logic i_Switch_1;
  logic i_Switch_2;
  logic o_LED_1;
  logic o_Grant_1;
  logic o_Grant_2;
  logic o_Busy;

  modport master (
    output i_Switch_1, i_Switch_2,
    input  o_LED_1, o_Grant_1, o_Grant_2, o_Busy
  );

  modport slave (
    input  i_Switch_1, i_Switch_2,
    output o_LED_1, o_Grant_1, o_Grant_2, o_Busy
  );
endinterface

// File: rtl/switch_led_arbiter.sv
// Two debounced switches arbitrate round-robin for one shared LED, with a
// minimum hold time per grant and a one-cycle IDLE gap between grants.
// Optional macro LED_BLINK_OWNER_EN: blink the shared LED while requester 2
// owns it (half-period BLINK_CYCLES); without it the LED simply mirrors busy.
module switch_led_arbiter #(
  parameter int unsigned DEBOUNCE_LIMIT = 250000,
  parameter int unsigned HOLD_CYCLES    = 12500000,
  parameter int unsigned BLINK_CYCLES   = 3125000
) (
  input logic                  i_Clk,
  input logic                  i_Rst_L,
  switch_led_arbiter_if.slave  bus
);

  localparam int unsigned DW = $clog2(DEBOUNCE_LIMIT) + 1;
  localparam int unsigned HW = $clog2(HOLD_CYCLES) + 1;

  // Reject illegal parameterisations at elaboration.
  if (DEBOUNCE_LIMIT < 1 || HOLD_CYCLES < 1 || BLINK_CYCLES < 1) begin : g_bad_param
    $error("switch_led_arbiter: DEBOUNCE_LIMIT, HOLD_CYCLES and BLINK_CYCLES must be >= 1");
  end

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT1 = 2'd1,
    GRANT2 = 2'd2
  } state_t;

  logic [1:0]    sync_meta;
  logic [1:0]    sync_q;
  logic [1:0]    deb_q;
  logic [DW-1:0] deb_cnt [2];
  logic [HW-1:0] hold_cnt;
  logic          last_owner_2;
  state_t        state;
  state_t        next_state;
  logic          grant_1_c;
  logic          grant_2_c;
  logic          busy_c;

  // Two-flop synchronizer per raw switch; bit 0 = switch 1, bit 1 = switch 2.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      sync_meta <= '0;
      sync_q    <= '0;
    end else begin
      sync_meta <= {bus.i_Switch_2, bus.i_Switch_1};
      sync_q    <= sync_meta;
    end
  end

  // Debounce: adopt the synced level only after it differs for DEBOUNCE_LIMIT cycles.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      deb_q <= '0;
      for (int i = 0; i < 2; i++) deb_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (sync_q[i] == deb_q[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DW'(DEBOUNCE_LIMIT - 1)) begin
          deb_q[i]   <= sync_q[i];
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + DW'(1);
        end
      end
    end
  end

  // FSM state register.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) state <= IDLE;
    else          state <= next_state;
  end

  // Next-state: round-robin from IDLE, no preemption, exit after hold and release.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (deb_q[0] && (!deb_q[1] || last_owner_2)) next_state = GRANT1;
        else if (deb_q[1])                           next_state = GRANT2;
      end
      GRANT1: if (hold_cnt == '0 && !deb_q[0]) next_state = IDLE;
      GRANT2: if (hold_cnt == '0 && !deb_q[1]) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Hold counter and last owner: load on grant entry, count down and saturate.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      hold_cnt     <= '0;
      last_owner_2 <= 1'b1;
    end else if (state == IDLE && next_state != IDLE) begin
      hold_cnt     <= HW'(HOLD_CYCLES - 1);
      last_owner_2 <= (next_state == GRANT2);
    end else if (state != IDLE && hold_cnt != '0) begin
      hold_cnt <= hold_cnt - HW'(1);
    end
  end

  // Output decode from next state so the registered outputs track the state.
  always_comb begin
    grant_1_c = (next_state == GRANT1);
    grant_2_c = (next_state == GRANT2);
    busy_c    = (next_state != IDLE);
  end

  // Registered grant/busy outputs.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      bus.o_Grant_1 <= 1'b0;
      bus.o_Grant_2 <= 1'b0;
      bus.o_Busy    <= 1'b0;
    end else begin
      bus.o_Grant_1 <= grant_1_c;
      bus.o_Grant_2 <= grant_2_c;
      bus.o_Busy    <= busy_c;
    end
  end

`ifdef LED_BLINK_OWNER_EN
  localparam int unsigned BW = $clog2(BLINK_CYCLES) + 1;

  logic [BW-1:0] blink_cnt;

  // Shared LED: steady for owner 1, blinking for owner 2 starting on, off in IDLE.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      bus.o_LED_1 <= 1'b0;
      blink_cnt   <= '0;
    end else begin
      case (next_state)
        GRANT1: begin
          bus.o_LED_1 <= 1'b1;
          blink_cnt   <= '0;
        end
        GRANT2: begin
          if (state != GRANT2) begin
            bus.o_LED_1 <= 1'b1;
            blink_cnt   <= '0;
          end else if (blink_cnt == BW'(BLINK_CYCLES - 1)) begin
            bus.o_LED_1 <= ~bus.o_LED_1;
            blink_cnt   <= '0;
          end else begin
            blink_cnt <= blink_cnt + BW'(1);
          end
        end
        default: begin
          bus.o_LED_1 <= 1'b0;
          blink_cnt   <= '0;
        end
      endcase
    end
  end
`else
  // Shared LED simply shows that the resource is in use.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) bus.o_LED_1 <= 1'b0;
    else          bus.o_LED_1 <= busy_c;
  end
`endif

endmodule
